// File: rtl/crc_pkg.sv
// Shared types and constants for the streaming CRC block.
// Holds the FSM state encoding and the common generator polynomials.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [31:0] CRC8_POLY        = 32'h0000_0007;
    localparam logic [31:0] CRC16_CCITT_POLY = 32'h0000_1021;

endpackage

// File: rtl/crc_step_n.sv
// Unrolled DATA_W-bit CRC update: purely combinational, zero latency.
// No flow control; the caller decides when the result is committed.
module crc_step_n #(
    parameter int               DATA_W    = 8,
    parameter int               CRC_W     = 8,
    parameter logic [CRC_W-1:0] POLY      = 'h07,
    parameter int               MSB_FIRST = 1
) (
    input  logic [CRC_W-1:0]  i_crc,
    input  logic [DATA_W-1:0] i_data,
    output logic [CRC_W-1:0]  o_crc
);

    logic [CRC_W-1:0] w_reg;
    logic             w_bit;
    logic             w_fb;

    always_comb begin
        w_reg = i_crc;
        w_bit = 1'b0;
        w_fb  = 1'b0;
        for (int i = 0; i < DATA_W; i++) begin
            w_bit = (MSB_FIRST != 0) ? i_data[DATA_W-1-i] : i_data[i];
            w_fb  = w_reg[CRC_W-1] ^ w_bit;
            w_reg = {w_reg[CRC_W-2:0], 1'b0} ^ (w_fb ? POLY : '0);
        end
        o_crc = w_reg;
    end

endmodule

// File: rtl/crc_stream.sv
// Frame CRC engine: one beat per cycle, result registered 1 cycle after the last beat.
// s_ready drops while a result waits in HOLD; the consumer releases it with crc_ready.
module crc_stream
    import crc_pkg::*;
#(
    parameter int               DATA_W    = 8,
    parameter int               CRC_W     = 8,
    parameter logic [CRC_W-1:0] POLY      = CRC_W'(CRC8_POLY),
    parameter logic [CRC_W-1:0] INIT      = '1,
    parameter logic [CRC_W-1:0] XOR_OUT   = '0,
    parameter int               MSB_FIRST = 1,
    parameter logic [CRC_W-1:0] RESIDUE   = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              crc_valid,
    input  logic              crc_ready,
    output logic [CRC_W-1:0]  crc,
    output logic              match,
    output logic [15:0]       frame_len
);

    state_t           r_state;
    logic             r_active;
    logic [CRC_W-1:0] r_reg;
    logic [CRC_W-1:0] r_crc;
    logic             r_match;
    logic [15:0]      r_cnt;
    logic [15:0]      r_frame_len;

    logic [CRC_W-1:0] w_next;
    logic [15:0]      w_cnt_nxt;
    logic             w_acc;

    crc_step_n #(
        .DATA_W   (DATA_W),
        .CRC_W    (CRC_W),
        .POLY     (POLY),
        .MSB_FIRST(MSB_FIRST)
    ) u_step (
        .i_crc (r_reg),
        .i_data(s_data),
        .o_crc (w_next)
    );

    // r_active keeps s_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_active <= 1'b0;
        else      r_active <= 1'b1;
    end

    assign s_ready   = r_active && (r_state != HOLD);
    assign w_acc     = s_valid && s_ready && !init;
    assign w_cnt_nxt = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_reg       <= INIT;
            r_crc       <= INIT ^ XOR_OUT;
            r_match     <= 1'b0;
            r_cnt       <= 16'd0;
            r_frame_len <= 16'd0;
        end else if (init) begin
            r_state     <= IDLE;
            r_reg       <= INIT;
            r_cnt       <= 16'd0;
            r_frame_len <= 16'd0;
        end else begin
            unique case (r_state)
                IDLE, RUN: begin
                    if (w_acc) begin
                        r_reg <= w_next;
                        r_cnt <= w_cnt_nxt;
                        if (s_last) begin
                            r_state     <= HOLD;
                            r_crc       <= w_next ^ XOR_OUT;
                            r_match     <= (w_next == RESIDUE);
                            r_frame_len <= w_cnt_nxt;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                HOLD: begin
                    // Counter restarts here so the next frame's first beat counts as 1.
                    if (crc_ready) begin
                        r_state <= IDLE;
                        r_reg   <= INIT;
                        r_cnt   <= 16'd0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_reg   <= INIT;
                    r_cnt   <= 16'd0;
                end
            endcase
        end
    end

    assign crc_valid = (r_state == HOLD);
    assign crc       = r_crc;
    assign match     = r_match;
    assign frame_len = r_frame_len;

endmodule

// File: doc/crc_stream.md
CRC_STREAM -- requirements
Module: crc_stream

Interface
REQ-001 Parameter DATA_W, default 8, sets input beat width in bits (1..64).
REQ-002 Parameter CRC_W, default 8, sets CRC register width (3..32).
REQ-003 Parameter POLY, default 'h07, is the generator polynomial without the implicit top bit.
REQ-004 Parameter INIT, default all-ones, is the register value at reset, init and frame start.
REQ-005 Parameter XOR_OUT, default 0, is XORed onto the register to form the result.
REQ-006 Parameter MSB_FIRST, default 1: 1 processes din[DATA_W-1] first, 0 processes din[0] first.
REQ-007 Parameter RESIDUE, default 0, is the expected register value after message plus appended CRC.
REQ-008 clk  in  1  clock; the block uses one clock and reset is asynchronous and active-low.
REQ-009 rst  in  1  asynchronous active-low reset.
REQ-010 init  in  1  synchronous active-high clear/abort.
REQ-011 s_valid  in  1  input beat valid.
REQ-012 s_ready  out  1  block accepts a beat.
REQ-013 s_data  in  DATA_W  beat data.
REQ-014 s_last  in  1  beat is the final beat of the frame.
REQ-015 crc_valid  out  1  result pending.
REQ-016 crc_ready  in  1  consumer accepts the result.
REQ-017 crc  out  CRC_W  final CRC, already XORed with XOR_OUT.
REQ-018 match  out  1  raw register equalled RESIDUE at frame end.
REQ-019 frame_len  out  16  accepted beat count of the frame, saturating at 16'hFFFF.

Function
REQ-020 A beat is accepted when s_valid and s_ready are both high on a rising clk edge.
REQ-021 The per-bit step is fb = reg[CRC_W-1] ^ bit; reg = {reg[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
REQ-022 An accepted beat applies DATA_W steps in one cycle, in the order set by MSB_FIRST.
REQ-023 The FSM has three states: IDLE (reg = INIT, s_ready=1), RUN (mid-frame, s_ready=1) and HOLD (result pending, s_ready=0, crc_valid=1).
REQ-024 IDLE goes to RUN on an accepted beat with s_last=0, and to HOLD on an accepted beat with s_last=1 (single-beat frame).
REQ-025 RUN goes to HOLD on an accepted beat with s_last=1 and stays in RUN otherwise; the register holds value when no beat is accepted.
REQ-026 On entry to HOLD, the block registers crc = next_reg ^ XOR_OUT, match = (next_reg == RESIDUE) and frame_len, with 1-cycle latency from the last beat.
REQ-027 HOLD goes to IDLE on crc_valid && crc_ready; the register reloads INIT in the same edge.
REQ-028 crc, match and frame_len hold stable while in HOLD and keep their last value after leaving it.
REQ-029 frame_len counts accepted beats including the last, restarts at 1 on the first beat of the next frame and saturates without wrap.
REQ-030 init has priority over every handshake: state goes to IDLE, reg to INIT, crc_valid to 0 and frame_len to 0, and any beat presented in that cycle is not accepted.
REQ-031 s_ready is combinational from state only and never depends on s_valid.

Reset
REQ-032 While rst=0: state=IDLE, reg=INIT, crc=INIT^XOR_OUT, crc_valid=0, match=0, frame_len=0, s_ready=0.
REQ-033 s_ready rises in the first cycle after rst deasserts; reset mid-frame or mid-HOLD discards the frame with no result.

Structure
REQ-034 Package crc_pkg holds the state enum (IDLE, RUN, HOLD) and the standard polynomial constants CRC8_POLY='h07 and CRC16_CCITT_POLY='h1021.
REQ-035 The single sub-module is crc_step_n, a combinational unrolled DATA_W-step update, parameterised identically.

Verification
REQ-036 The bench shall cover these scenarios:
- Defaults with INIT=0, beats "123456789" ASCII, last on '9' -> crc=8'hF4, frame_len=9, crc_valid 1 cycle after last.
- CRC_W=16, POLY='h1021, INIT='hFFFF, DATA_W=8, same message -> crc=16'h29B1.
- INIT=0, DATA_W=16, message "123456789" padded as 16-bit beats ending 8'h39 then 8'hF4, RESIDUE=0 -> match=1; corrupt one bit -> match=0.
- Frame ends with crc_ready held low for 5 cycles -> s_ready=0, crc/match stable, new s_valid ignored; crc_ready=1 -> IDLE next cycle.
- init pulsed after beat 4 of 9 -> no crc_valid; following clean frame yields 8'hF4 and frame_len=9.
- rst asserted mid-frame -> all outputs at reset values asynchronously; single-beat frame 8'h01 with INIT=0 -> crc=8'h07, frame_len=1.
